i2s_tx_buf: RTL and testbench

- Transmit sample buffer sitting directly upstream of the I2S protocol interface. It feeds that interface's data_in / data_in_valid / data_in_ack handshake.
- Accepts 32-bit stereo samples ({left[15:0], right[15:0]}) from the APB register side and stores them in a first-word-fall-through FIFO.
- Presents the head entry to the I2S interface, which pops it with a same-cycle acknowledge.
- Provides level, a threshold refill request, sticky overflow/underrun flags and a saturating underrun counter for the APB status registers.

---
 rtl/i2s_tx_buf.sv | 75 +++++++
 tb/tb_i2s_tx_buf.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/i2s_tx_buf.sv
// i2s_tx_buf: FWFT sample FIFO feeding the I2S interface, with refill request and sticky status.
module i2s_tx_buf #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  output logic          wr_full,
  input  logic          flush,
  output logic [AW:0]   level,
  input  logic [AW:0]   thresh,
  input  logic          irq_en,
  output logic          refill_req,
  output logic [DW-1:0] i2s_data,
  output logic          i2s_data_valid,
  input  logic          i2s_data_ack,
  input  logic          i2s_underrun,
  input  logic          status_clr,
  output logic          ovf_sticky,
  output logic          udr_sticky,
  output logic [7:0]    udr_count
);
  localparam int DEPTH = 2 ** AW;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          refill_q, refill_d, ovf_q, ovf_d, udr_q, udr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          push, pop;
  assign wr_full        = level_q == (AW+1)'(DEPTH);
  assign i2s_data_valid = level_q != '0;
  assign i2s_data       = mem_q[rd_ptr_q];
  assign level          = level_q;
  assign refill_req     = refill_q;
  assign ovf_sticky     = ovf_q;
  assign udr_sticky     = udr_q;
  assign udr_count      = cnt_q;
  // flush wins over both ends; a dropped write during flush is not an overflow
  always_comb begin
    push     = wr_en & ~wr_full & ~flush;
    pop      = i2s_data_ack & i2s_data_valid & ~flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    level_d  = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    refill_d = irq_en & (level_d <= thresh);
    ovf_d    = (wr_en & wr_full & ~flush) | (ovf_q & ~status_clr);
    udr_d    = i2s_underrun | (udr_q & ~status_clr);
    cnt_d    = i2s_underrun ? (status_clr ? 8'd1 : cnt_q + {7'd0, cnt_q != 8'hFF})
                            : (status_clr ? 8'd0 : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      refill_q <= 1'b0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      refill_q <= refill_d;
      ovf_q    <= ovf_d;
      udr_q    <= udr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_i2s_tx_buf.sv
// tb_i2s_tx_buf: queue-based model of the sample buffer checked every cycle, plus directed literal checks.
module tb_i2s_tx_buf;
  logic        clk = 0, rst_n = 0;
  logic [31:0] wr_data = 0;
  logic        wr_en = 0, flush = 0, irq_en = 0, ack = 0, und = 0, clr = 0;
  logic [3:0]  thresh = 0;
  logic        wr_full, refill_req, valid, ovf, udr;
  logic [3:0]  level;
  logic [31:0] i2s_data;
  logic [7:0]  udr_count;
  int checks = 0, failures = 0;
  bit chk_en = 0;

  i2s_tx_buf #(.AW(3), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .flush(flush), .level(level), .thresh(thresh), .irq_en(irq_en), .refill_req(refill_req),
    .i2s_data(i2s_data), .i2s_data_valid(valid), .i2s_data_ack(ack),
    .i2s_underrun(und), .status_clr(clr), .ovf_sticky(ovf), .udr_sticky(udr),
    .udr_count(udr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: contents as a queue, flags and count as plain variables
  logic [31:0] mq[$];
  bit m_ovf = 0, m_udr = 0, m_refill = 0;
  int m_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_udr = 0; m_refill = 0; m_cnt = 0;
    end else begin
      bit was_full;
      was_full = mq.size() == 8;
      m_ovf = (m_ovf && !clr) || (wr_en && was_full && !flush);
      if (clr) begin m_udr = 0; m_cnt = 0; end
      if (und) begin m_udr = 1; m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1; end
      if (flush) mq.delete();
      else begin
        if (ack && mq.size() > 0) void'(mq.pop_front());
        if (wr_en && !was_full) mq.push_back(wr_data);
      end
      m_refill = irq_en && (mq.size() <= int'(thresh));
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("m_level", 32'(level), 32'(mq.size()));
    chk("m_full", 32'(wr_full), 32'(mq.size() == 8));
    chk("m_valid", 32'(valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", i2s_data, mq[0]);
    chk("m_refill", 32'(refill_req), 32'(m_refill));
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
    chk("m_udr", 32'(udr), 32'(m_udr));
    chk("m_cnt", 32'(udr_count), 32'(m_cnt));
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic wr(input logic [31:0] d); wr_en = 1; wr_data = d; step(); wr_en = 0; endtask
  task automatic pop(); ack = 1; step(); ack = 0; endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk_en = 1;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_refill", 32'(refill_req), 0);
    wr(32'h1234_ABCD);
    chk("w1_valid", 32'(valid), 1);
    chk("w1_data", i2s_data, 32'h1234_ABCD);
    chk("w1_level", 32'(level), 1);
    pop();
    chk("p1_level", 32'(level), 0);
    chk("p1_valid", 32'(valid), 0);
    for (int i = 0; i < 8; i++) wr(i);
    chk("fill_full", 32'(wr_full), 1);
    chk("fill_level", 32'(level), 8);
    wr(32'hDEAD);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_level", 32'(level), 8);
    for (int i = 0; i < 8; i++) begin
      chk("order", i2s_data, i);
      pop();
    end
    chk("drained", 32'(valid), 0);
    clr = 1; step(); clr = 0;
    chk("ovf_clr", 32'(ovf), 0);
    wr(32'hA1);
    wr_en = 1; wr_data = 32'hB2; ack = 1; step(); wr_en = 0; ack = 0;
    chk("pp_level", 32'(level), 1);
    chk("pp_head", i2s_data, 32'hB2);
    pop();
    pop();
    chk("ack_empty", 32'(level), 0);
    thresh = 2; irq_en = 1; step();
    chk("refill_empty", 32'(refill_req), 1);
    for (int i = 0; i < 4; i++) wr(32'h100 + i);
    chk("refill_l4", 32'(refill_req), 0);
    pop();
    chk("refill_l3", 32'(refill_req), 0);
    pop();
    chk("refill_l2", 32'(refill_req), 1);
    chk("refill_lvl2", 32'(level), 2);
    irq_en = 0; step();
    chk("refill_off", 32'(refill_req), 0);
    und = 1; repeat (300) step(); und = 0;
    chk("udr_sat", 32'(udr_count), 32'hFF);
    chk("udr_set", 32'(udr), 1);
    und = 1; clr = 1; step(); und = 0; clr = 0;
    chk("udr_clr_set", 32'(udr_count), 1);
    chk("udr_clr_flag", 32'(udr), 1);
    clr = 1; step(); clr = 0;
    chk("udr_cleared", 32'(udr_count), 0);
    chk("udr_flag_clr", 32'(udr), 0);
    for (int i = 0; i < 3; i++) wr(32'h200 + i);
    chk("pre_flush", 32'(level), 5);
    flush = 1; wr_en = 1; wr_data = 32'h300; step(); flush = 0; wr_en = 0;
    chk("flush_level", 32'(level), 0);
    chk("flush_valid", 32'(valid), 0);
    chk("flush_ovf", 32'(ovf), 0);
    for (int i = 0; i < 3; i++) wr(32'h400 + i);
    chk("pre_rst", 32'(level), 3);
    rst_n = 0; #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_level", 32'(level), 0);
    #5 rst_n = 1;
    step();
    wr(32'h55AA);
    chk("post_rst_data", i2s_data, 32'h55AA);
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
